// File: rtl/truth_table_bist.sv
// Exhaustive self-test engine for the 4-input truth_table function.
// Walks all 16 vectors, compares the DUT response against a built-in golden model.
module truth_table_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [3:0]       abcd,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t           state, state_n;
  logic [3:0]       vec, vec_n;
  logic [3:0]       settle_cnt, settle_cnt_n;
  logic [ERR_W-1:0] err_q, err_n;
  logic [3:0]       ffv_q, ffv_n;
  logic             ffval_q, ffval_n;
  logic             exp_y;

  // Golden model on the registered vector: A&C | A&B | ~A&~D
  assign exp_y = (vec[3] & vec[1]) | (vec[3] & vec[2]) | (~vec[3] & ~vec[0]);

  // Handshake: start is a single-cycle level sampled on the rising edge; it is
  // accepted only in IDLE or DONE and ignored while busy is high.
  always_comb begin
    state_n      = state;
    vec_n        = vec;
    settle_cnt_n = settle_cnt;
    err_n        = err_q;
    ffv_n        = ffv_q;
    ffval_n      = ffval_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = SETTLE;
          vec_n        = 4'd0;
          settle_cnt_n = 4'd0;
          err_n        = '0;
          ffv_n        = 4'd0;
          ffval_n      = 1'b0;
        end
      end
      SETTLE: begin
        settle_cnt_n = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) state_n = CHECK;
      end
      CHECK: begin
        if (y != exp_y) begin
          if (err_q != ERR_MAX) err_n = err_q + ERR_W'(1);
          if (!ffval_q) begin
            ffv_n   = vec;
            ffval_n = 1'b1;
          end
        end
        if (vec == 4'd15) begin
          state_n = DONE;
        end else begin
          vec_n        = vec + 4'd1;
          settle_cnt_n = 4'd0;
          state_n      = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= 4'd0;
      settle_cnt <= 4'd0;
      err_q      <= '0;
      ffv_q      <= 4'd0;
      ffval_q    <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      settle_cnt <= settle_cnt_n;
      err_q      <= err_n;
      ffv_q      <= ffv_n;
      ffval_q    <= ffval_n;
    end
  end

  // Every output is a decode of registers only; y never reaches an output directly.
  assign abcd             = vec;
  assign busy             = (state == SETTLE) || (state == CHECK);
  assign done             = (state == DONE);
  assign pass             = (state == DONE) && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_truth_table_bist.sv
// Directed bench for truth_table_bist: three instances cover default, ERR_W=3
// and SETTLE_CYCLES=1 configurations, each fed by a selectable fault model.
module tb_truth_table_bist;

  logic       clk;
  logic       reset;
  logic       start_v [3];
  logic [3:0] abcd_v  [3];
  logic       y_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [7:0] err_v   [3];
  logic [3:0] ffv_v   [3];
  logic       ffval_v [3];
  logic [1:0] st_v    [3];
  int         mode_v  [3];

  logic [4:0] err_d0;
  logic [2:0] err_e3;
  logic [4:0] err_s1;

  int checks;
  int failures;

  // Mode 0: correct DUT, 1: stuck-at-0, 2: stuck-at-1, 3: inverted
  function automatic logic dut_model(input int mode, input logic [3:0] v);
    logic [15:0] tt;
    logic        g;
    tt = 16'hFC55;
    g  = tt[v];
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~g;
      default: return g;
    endcase
  endfunction

  assign y_v[0] = dut_model(mode_v[0], abcd_v[0]);
  assign y_v[1] = dut_model(mode_v[1], abcd_v[1]);
  assign y_v[2] = dut_model(mode_v[2], abcd_v[2]);
  assign err_v[0] = {3'd0, err_d0};
  assign err_v[1] = {5'd0, err_e3};
  assign err_v[2] = {3'd0, err_s1};

  truth_table_bist u_dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .abcd(abcd_v[0]), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_d0),
    .first_fail_vec(ffv_v[0]), .first_fail_valid(ffval_v[0]), .state_dbg(st_v[0])
  );

  truth_table_bist #(.SETTLE_CYCLES(2), .ERR_W(3)) u_dut_e3 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abcd(abcd_v[1]), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_e3),
    .first_fail_vec(ffv_v[1]), .first_fail_valid(ffval_v[1]), .state_dbg(st_v[1])
  );

  truth_table_bist #(.SETTLE_CYCLES(1), .ERR_W(5)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start_v[2]), .abcd(abcd_v[2]), .y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_s1),
    .first_fail_vec(ffv_v[2]), .first_fail_valid(ffval_v[2]), .state_dbg(st_v[2])
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on instance i, count busy cycles, optionally re-pulse start mid-run.
  task automatic run(input int i, input int exp_cycles, input bit poke_mid, input string tag);
    int n;
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    check({tag, "_busy_rise"}, busy_v[i], 1);
    check({tag, "_abcd0"}, abcd_v[i], 0);
    check({tag, "_cleared"}, {done_v[i], ffval_v[i], err_v[i]}, 0);
    n = 0;
    while (busy_v[i] && n < 200) begin
      n++;
      if (poke_mid && n == 5) start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_done"}, done_v[i], 1);
    check({tag, "_last_vec"}, abcd_v[i], 15);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_abcd"}, abcd_v[0], 0);
    check({tag, "_busy"}, busy_v[0], 0);
    check({tag, "_done"}, done_v[0], 0);
    check({tag, "_pass"}, pass_v[0], 0);
    check({tag, "_err"}, err_v[0], 0);
    check({tag, "_ffv"}, ffv_v[0], 0);
    check({tag, "_ffval"}, ffval_v[0], 0);
    check({tag, "_state"}, st_v[0], 0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 0;
    end
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Correct DUT, defaults
    run(0, 48, 1'b0, "good");
    check("good_pass", pass_v[0], 1);
    check("good_err", err_v[0], 0);
    check("good_ffval", ffval_v[0], 0);

    // Stuck-at-0, restarted from DONE
    mode_v[0] = 1;
    run(0, 48, 1'b0, "sa0");
    check("sa0_err", err_v[0], 10);
    check("sa0_ffv", ffv_v[0], 0);
    check("sa0_ffval", ffval_v[0], 1);
    check("sa0_pass", pass_v[0], 0);

    // Stuck-at-1: previous errors must be cleared on restart
    mode_v[0] = 2;
    run(0, 48, 1'b0, "sa1");
    check("sa1_err", err_v[0], 6);
    check("sa1_ffv", ffv_v[0], 1);
    check("sa1_ffval", ffval_v[0], 1);
    check("sa1_pass", pass_v[0], 0);

    // Inverted DUT with a 3-bit saturating counter
    mode_v[1] = 3;
    run(1, 48, 1'b0, "inv");
    check("inv_err_sat", err_v[1], 7);
    check("inv_ffv", ffv_v[1], 0);
    check("inv_pass", pass_v[1], 0);

    // SETTLE_CYCLES=1: mid-run start ignored, then restart from DONE
    mode_v[2] = 0;
    run(2, 32, 1'b1, "s1a");
    check("s1a_pass", pass_v[2], 1);
    run(2, 32, 1'b0, "s1b");
    check("s1b_pass", pass_v[2], 1);

    // Asynchronous reset at vector 7 of a stuck-at-0 run
    mode_v[0] = 1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    n = 0;
    while (abcd_v[0] != 4'd7 && n < 100) begin
      n++;
      tick();
    end
    check("reach_vec7", abcd_v[0], 7);
    #1 reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    tick();
    check_reset_vals("mid_rst_next");
    reset = 1'b0;
    tick();
    run(0, 48, 1'b0, "post_rst");
    check("post_rst_err", err_v[0], 10);
    check("post_rst_ffv", ffv_v[0], 0);
    check("post_rst_pass", pass_v[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
